sreg_stream_ctrl: RTL and testbench
===================================

# sreg_stream_ctrl

Valid/ready streaming controller around one `sreg` delay line of `DEPTH` stages. It decides when the line shifts, tracks which stages hold live data through a parallel valid-bit chain, and applies output backpressure. It also provides a flush mode that drains in-flight beats by injecting bubbles. It sits between an upstream producer and the systolic-array feeders that need fixed-depth operand skew with a proper handshake.

## Interface
- `D_W`, 32, data width in bits.
- `DEPTH`, 8, number of shift stages; must be ≥ 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset. Active-low and asynchronous: assertion clears the state immediately; deassertion is synchronous to `clk`.
- `s_valid`  in  1  input beat present.
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`.
- `s_data`  in  D_W  input beat, signed.
- `flush`  in  1  single-cycle request to drain the line.
- `m_valid`  out  1  output beat present.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  D_W  output beat; equals the last `sreg` stage.
- `busy`  out  1  high while in FLUSH.
- `occupancy`  out  $clog2(DEPTH+1)  number of live beats in the line.

## Operation
- `vld[DEPTH-1:0]` is the valid-bit chain and is resettable. The `sreg` data stages are not reset.
- `m_valid = vld[DEPTH-1]`.
- `blocked = m_valid && !m_ready`.
- `s_ready = (state==RUN) && !blocked`.
- `advance` (drives `shift_en`):
  - RUN: `s_valid && s_ready`.
  - FLUSH: `!blocked`.
- On advance:
  - The `sreg` shifts. `data_in` is `s_data` in RUN and 0 in FLUSH.
  - `vld` shifts with the new bit = 1 in RUN and 0 in FLUSH.
- Output fire (`m_valid && m_ready`) without advance clears `vld[DEPTH-1]`. With advance, the shift overwrites that bit.
- `occupancy`: +1 on input accept, −1 on output fire, unchanged when both happen in the same cycle. It never exceeds DEPTH.
- FSM (states RUN, FLUSH):
  - RUN → FLUSH when `flush && (occupancy != 0 || input accepted this cycle)`.
  - `flush` with an empty line and no accept is ignored.
  - A beat accepted in the same cycle as `flush` is included in the drain.
  - FLUSH → RUN in the cycle `occupancy` becomes 0, i.e. after the last live beat fires.
  - `flush` is ignored while in FLUSH.
- In RUN, data moves only when new beats enter. A beat therefore reaches the output only after DEPTH−1 later accepts, or after a flush.

## Timing
- Reset values: `m_valid`=0, `s_ready`=1, `busy`=0, `occupancy`=0, state RUN, `vld`=0. `m_data` is undefined until `m_valid`.
- An advance at edge t makes the new `m_data`/`m_valid` visible after t; there is no extra output register.
- Beat accepted at edge t reaches the output after DEPTH−1 further advances.
- In FLUSH with `m_ready` held high, one advance happens per cycle. Live beats emerge in order with no reordering; bubbles never assert `m_valid`.
- While `blocked`, `m_data` and `m_valid` hold stable and nothing shifts.
- Reset asserted mid-flush or mid-stream discards all beats: `vld`=0, state RUN.

## Structure
- Package `sreg_ctrl_pkg` contains:
  - `typedef enum logic {ST_RUN, ST_FLUSH} sreg_ctrl_state_t`.
  - Occupancy-width helper function.
- The data path is one instance of the existing `sreg` (D_W, DEPTH), driven by `advance` and the muxed `data_in`.
- The valid chain, occupancy counter and FSM stay in this module.

## Test plan
All scenarios use DEPTH=4, D_W=8.
- **Reset:** hold `rst`=0 for 3 cycles, release → `m_valid`=0, `s_ready`=1, `busy`=0, `occupancy`=0.
- **Streaming:** push 1..8 with `m_ready`=1 → `m_valid` first rises after the 4th accept with `m_data`=1. Outputs are 1,2,3,4,5 in order by the 8th accept. `occupancy` peaks at 4 and ends at 3.
- **Backpressure:** push 1..4, then `m_ready`=0 → `m_valid`=1, `m_data`=1, `s_ready`=0, held for 10 cycles. Raise `m_ready` → 1 fires, `occupancy`=3, `s_ready`=1.
- **Flush:** push A=0x11, B=0x22, C=0x33, pulse `flush`, `m_ready`=1 → `busy`=1, outputs 0x11, 0x22, 0x33 on consecutive cycles with no bubbles asserted. `busy`=0 and `occupancy`=0 after the 0x33 fire.
- **Flush edge cases:**
  - Pulse `flush` on an empty line → `busy` stays 0.
  - `flush` with `s_valid` in the same cycle → that beat is accepted and drained.
- **Reset mid-flush:** assert `rst` during a flush with 2 beats live → `m_valid`=0 and `occupancy`=0 immediately; those beats never appear after release.

Source files
------------

// File: rtl/sreg_ctrl_pkg.sv
// Shared types and helpers for the sreg valid/ready stream controller.
package sreg_ctrl_pkg;

  typedef enum logic {ST_RUN, ST_FLUSH} sreg_ctrl_state_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sreg.sv
// Plain enabled shift register of DEPTH data stages; stages are intentionally not reset.
module sreg #(
  parameter int D_W   = 32,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           shift_en,
  input  logic [D_W-1:0] data_in,
  output logic [D_W-1:0] data_out
);

  logic [D_W-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      stages[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign data_out = stages[DEPTH-1];

endmodule

// File: rtl/sreg_stream_ctrl.sv
// Valid/ready wrapper around one sreg delay line: valid-bit chain, occupancy
// tracking, output backpressure and a bubble-injecting flush mode.
module sreg_stream_ctrl
  import sreg_ctrl_pkg::*;
#(
  parameter int D_W   = 32,
  parameter int DEPTH = 8,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [D_W-1:0] s_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [D_W-1:0] m_data,
  output logic                  busy,
  output logic [OCC_W-1:0]      occupancy
);

  sreg_ctrl_state_t state;
  logic [DEPTH-1:0] vld;
  logic             in_run;
  logic             blocked;
  logic             accept;
  logic             fire;
  logic             advance;
  logic [D_W-1:0]   data_in;
  logic [D_W-1:0]   data_out;
  logic [OCC_W-1:0] occ_next;

  assign in_run  = (state == ST_RUN);
  assign m_valid = vld[DEPTH-1];
  assign blocked = m_valid && !m_ready;
  assign s_ready = in_run && !blocked;
  assign accept  = s_valid && s_ready;
  assign fire    = m_valid && m_ready;
  assign advance = in_run ? accept : !blocked;
  // Flush pushes zero bubbles so the live beats walk out behind the last one.
  assign data_in = in_run ? s_data : '0;
  assign m_data  = data_out;

  sreg #(
    .D_W   (D_W),
    .DEPTH (DEPTH)
  ) u_sreg (
    .clk      (clk),
    .shift_en (advance),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always_comb begin
    occ_next = occupancy;
    case ({accept, fire})
      2'b10:   occ_next = occupancy + OCC_W'(1);
      2'b01:   occ_next = occupancy - OCC_W'(1);
      default: occ_next = occupancy;
    endcase
  end

  // A fire without a shift must retire the output beat; a shift overwrites it anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      busy      <= 1'b0;
      vld       <= '0;
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
      if (advance) begin
        vld <= {vld[DEPTH-2:0], in_run};
      end else if (fire) begin
        vld[DEPTH-1] <= 1'b0;
      end
      case (state)
        ST_RUN: begin
          if (flush && (occupancy != '0 || accept)) begin
            state <= ST_FLUSH;
            busy  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (occ_next == '0) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_stream_ctrl.sv
// Directed bench for sreg_stream_ctrl (DEPTH=4, D_W=8) with an in-order output scoreboard.
module tb_sreg_stream_ctrl;

  localparam int D_W   = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic signed [D_W-1:0] s_data;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic signed [D_W-1:0] m_data;
  logic                  busy;
  logic [OCC_W-1:0]      occupancy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fire_cnt  = 0;
  logic [D_W-1:0] sb_q[$];

  sreg_stream_ctrl #(
    .D_W   (D_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .busy      (busy),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: scoreboard the handshakes at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [D_W-1:0] exp;
    @(negedge clk);
    if (rst && m_valid && m_ready) begin
      fire_cnt++;
      if (sb_q.size() == 0) begin
        total_cnt++;
        $error("[TB] FAIL sb_unexpected_beat: observed %0h expected none", m_data);
      end else begin
        exp = sb_q.pop_front();
        check_output("sb_data", 32'(m_data), 32'(exp));
      end
    end
    if (rst && s_valid && s_ready) sb_q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    flush   = 1'b0;
    m_ready = 1'b1;
    sb_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic apply_stimulus(input logic [D_W-1:0] value);
    s_valid = 1'b1;
    s_data  = value;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check_output(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset
    apply_reset();
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_s_ready", 32'(s_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_occupancy", 32'(occupancy), 32'd0);

    // Streaming 1..8 with the sink always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(D_W'(i));
      check_output("stream_occ", 32'(occupancy), (i < DEPTH) ? 32'(i) : 32'(DEPTH));
      check_output("stream_m_valid", 32'(m_valid), (i < DEPTH) ? 32'd0 : 32'd1);
      if (i >= DEPTH) check_output("stream_m_data", 32'(m_data), 32'(i - DEPTH + 1));
    end
    tick();
    check_output("stream_occ_end", 32'(occupancy), 32'd3);
    check_output("stream_fired", 32'(fire_cnt), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("stream_flush_busy", 32'(busy), 32'd1);
    wait_idle("stream_drain_done");
    check_output("stream_drain_occ", 32'(occupancy), 32'd0);
    check_output("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure
    apply_reset();
    for (int i = 1; i <= 4; i++) apply_stimulus(D_W'(i));
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("bp_m_valid", 32'(m_valid), 32'd1);
      check_output("bp_m_data", 32'(m_data), 32'd1);
      check_output("bp_s_ready", 32'(s_ready), 32'd0);
      check_output("bp_occ", 32'(occupancy), 32'd4);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    check_output("bp_release_occ", 32'(occupancy), 32'd3);
    check_output("bp_release_s_ready", 32'(s_ready), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("bp_drain_done");
    check_output("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Flush drains three beats back-to-back
    apply_reset();
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("fl_busy", 32'(busy), 32'd1);
    tick();
    check_output("fl_v0", 32'(m_valid), 32'd1);
    check_output("fl_d0", 32'(m_data), 32'h11);
    tick();
    check_output("fl_v1", 32'(m_valid), 32'd1);
    check_output("fl_d1", 32'(m_data), 32'h22);
    tick();
    check_output("fl_v2", 32'(m_valid), 32'd1);
    check_output("fl_d2", 32'(m_data), 32'h33);
    tick();
    check_output("fl_busy_end", 32'(busy), 32'd0);
    check_output("fl_occ_end", 32'(occupancy), 32'd0);
    check_output("fl_m_valid_end", 32'(m_valid), 32'd0);
    check_output("fl_sb_empty", 32'(sb_q.size()), 32'd0);

    // Flush on an empty line is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("fl_empty_busy", 32'(busy), 32'd0);
    check_output("fl_empty_occ", 32'(occupancy), 32'd0);

    // Flush together with an accepted beat drains that beat
    s_valid = 1'b1;
    s_data  = 8'h5a;
    flush   = 1'b1;
    tick();
    s_valid = 1'b0;
    flush   = 1'b0;
    check_output("fl_acc_busy", 32'(busy), 32'd1);
    check_output("fl_acc_occ", 32'(occupancy), 32'd1);
    wait_idle("fl_acc_done");
    check_output("fl_acc_occ_end", 32'(occupancy), 32'd0);
    check_output("fl_acc_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a flush discards live beats
    apply_reset();
    apply_stimulus(8'h41);
    apply_stimulus(8'h42);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check_output("rmf_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_output("rmf_m_valid", 32'(m_valid), 32'd0);
    check_output("rmf_occ", 32'(occupancy), 32'd0);
    check_output("rmf_busy_clr", 32'(busy), 32'd0);
    sb_q.delete();
    tick();
    rst = 1'b1;
    repeat (8) begin
      tick();
      check_output("rmf_no_beats", 32'(m_valid), 32'd0);
    end
    check_output("rmf_s_ready", 32'(s_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
